// File: rtl/core_pkg.sv
// core_pkg: pipeline register types, bubble constant and load/store byte-lane helpers.
package core_pkg;
    localparam int DATA_MEM_DEPTH = 1024;
    localparam logic [31:0] NOP_INST = 32'h00000013;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM, WB_PC} wb_sel_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] alu_result;
        logic [31:0] pc_plus4;
        logic [31:0] rd_data2;
        logic [4:0]  rd_addr;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        wb_sel_t     wb_sel;
    } ex_mem_data_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] alu_result;
        logic [31:0] pc_plus4;
        logic [31:0] rd_data;
        logic [4:0]  rd_addr;
        logic        reg_write;
        wb_sel_t     wb_sel;
    } mem_wb_data_t;

    localparam mem_wb_data_t MEM_WB_BUBBLE = '{
        instruction: NOP_INST, alu_result: 32'h0, pc_plus4: 32'h0, rd_data: 32'h0,
        rd_addr: 5'd0, reg_write: 1'b0, wb_sel: WB_NONE
    };

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] funct3,
                                                input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        return funct3 == F3_B  ? {{24{b[7]}}, b} :
               funct3 == F3_BU ? {24'h0, b} :
               funct3 == F3_H  ? {{16{h[15]}}, h} :
               funct3 == F3_HU ? {16'h0, h} :
               funct3 == F3_W  ? word : 32'h0;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] off);
        return funct3 == F3_B ? 4'b0001 << off :
               funct3 == F3_H ? (off[1] ? 4'b1100 : 4'b0011) :
               funct3 == F3_W ? 4'b1111 : 4'b0000;
    endfunction
endpackage

// File: rtl/mem_stage_dmem_bram.sv
// dmem_bram: single-port synchronous data RAM with byte enables and read enable, block-RAM style.
module dmem_bram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              re,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory stage with data RAM and MEM/WB register.
// Define MISALIGN_TRAP_EN to suppress and flag misaligned half/word accesses.
module mem_stage
    import core_pkg::*;
#(
    parameter int DEPTH  = DATA_MEM_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_i,
    input  logic         flush_i,
    input  ex_mem_data_t ex_mem_i,
    output mem_wb_data_t mem_wb_o,
    output logic         misalign_o
);
    logic [2:0]        funct3;
    logic [1:0]        off;
    logic [ADDR_W-1:0] word_addr;
    logic              mis;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              re;
    logic              mem_read_q;
    mem_wb_data_t      wb_q;
    logic              unused_addr;

    assign funct3      = ex_mem_i.instruction[14:12];
    assign off         = ex_mem_i.alu_result[1:0];
    assign word_addr   = ex_mem_i.alu_result[ADDR_W+1:2];
    assign unused_addr = ^ex_mem_i.alu_result[31:ADDR_W+2];

`ifdef MISALIGN_TRAP_EN
    logic mis_q;
    assign mis = (ex_mem_i.mem_read | ex_mem_i.mem_write) &
                 (((funct3 == F3_H || funct3 == F3_HU) & off[0]) | (funct3 == F3_W && off != 2'b00));
    assign misalign_o = mis_q;
`else
    assign mis = 1'b0;
    assign misalign_o = 1'b0;
`endif

    assign be    = (ex_mem_i.mem_write & ~stall_i & ~flush_i & ~rst & ~mis) ? store_be(funct3, off) : 4'b0000;
    assign wdata = funct3 == F3_B ? {4{ex_mem_i.rd_data2[7:0]}} :
                   funct3 == F3_H ? {2{ex_mem_i.rd_data2[15:0]}} : ex_mem_i.rd_data2;
    // Gating the read under stall keeps the registered load word stable.
    assign re    = ex_mem_i.mem_read & ~stall_i;

    dmem_bram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk(clk),
        .re(re),
        .we(be),
        .addr(word_addr),
        .wdata(wdata),
        .rdata(rdata)
    );

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wb_q       <= MEM_WB_BUBBLE;
            mem_read_q <= 1'b0;
        end else if (!stall_i) begin
            wb_q <= '{
                instruction: ex_mem_i.instruction,
                alu_result:  ex_mem_i.alu_result,
                pc_plus4:    ex_mem_i.pc_plus4,
                rd_data:     32'h0,
                rd_addr:     ex_mem_i.rd_addr,
                reg_write:   ex_mem_i.reg_write & ~(mis & ex_mem_i.mem_read),
                wb_sel:      ex_mem_i.wb_sel
            };
            mem_read_q <= ex_mem_i.mem_read;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst || flush_i) mis_q <= 1'b0;
        else if (!stall_i) mis_q <= mis;
    end
`endif

    // Load data is extracted from the registered word using the registered funct3 and offset.
    always_comb begin
        mem_wb_o         = wb_q;
        mem_wb_o.rd_data = mem_read_q ? load_extend(rdata, wb_q.instruction[14:12], wb_q.alu_result[1:0]) : 32'h0;
    end
endmodule
